stage_mem: RTL and testbench

- Memory-access stage. Sits directly downstream of the execute stage and upstream of writeback.
- Registers the execute stage's outputs on each enabled clock edge, and performs the load or store over a request/acknowledge data bus.
- Formats load data (byte/half/word, sign- or zero-extended) and presents the destination register and result to writeback.
- Asserts `stall` to freeze all upstream stages while a bus access is outstanding.

---
 rtl/stage_mem_if.sv | 34 +++
 rtl/stage_mem.sv | 231 +++++++++++++++++++++++
 tb/tb_stage_mem.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/stage_mem_if.sv
// Data-bus interface between the memory-access stage and the data memory.
// The stage is the master. It drives the request, the direction, the
// word-aligned address, the byte enables and the write data. The memory
// returns a one-cycle acknowledge, and on a read it returns the read word
// in that same cycle.
interface stage_mem_if;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [3:0]  dbus_be;
    logic [31:0] dbus_wdata;
    logic        dbus_ack;
    logic [31:0] dbus_rdata;

    modport master (
        output dbus_req,
        output dbus_we,
        output dbus_addr,
        output dbus_be,
        output dbus_wdata,
        input  dbus_ack,
        input  dbus_rdata
    );

    modport slave (
        input  dbus_req,
        input  dbus_we,
        input  dbus_addr,
        input  dbus_be,
        input  dbus_wdata,
        output dbus_ack,
        output dbus_rdata
    );
endinterface

// File: rtl/stage_mem.sv
// Memory-access pipeline stage.
// This stage registers the results of the execute stage. It performs loads
// and stores over a request/acknowledge data bus, formats the load data and
// presents the result to writeback. While a bus access is outstanding it
// raises stall, which freezes every upstream stage. The bus request and the
// writeback outputs are combinational from the stage register. This lets
// back-to-back accesses run with no dead cycles, and it makes writeback
// valid in the acknowledge cycle itself.
module stage_mem (
    input  logic        clk,
    input  logic        rst,

    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_nextpc,
    input  logic [31:0] ex_alu_res,
    input  logic [31:0] ex_mem_data,
    input  logic [4:0]  ex_rd,
    input  logic        ex_w_rd,
    input  logic        ex_link,
    input  logic        ex_mem_rd,
    input  logic        ex_mem_wr,
    input  logic [1:0]  ex_mem_size,
    input  logic        ex_mem_sext,
    input  logic        ex_bubble,

    stage_mem_if.master dbus,

    output logic        stall,
    output logic [31:0] wb_pc,
    output logic [4:0]  wb_rd,
    output logic        wb_w_rd,
    output logic [31:0] wb_data,
    output logic        wb_bubble
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    // Access-size encodings. Size 3 is reserved and is handled as a word.
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;

    // ------------------------------------------------------------------
    // Bus-formatting helpers
    // ------------------------------------------------------------------

    // Byte enables for an access of the given size at byte offset a.
    function automatic logic [3:0] f_byte_en(input logic [1:0] size,
                                             input logic [1:0] a);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << a;
            SZ_HALF: be = a[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate narrow store data across every lane. The byte enables then
    // select the lane that is written.
    function automatic logic [31:0] f_store_data(input logic [1:0]  size,
                                                 input logic [31:0] d);
        logic [31:0] wd;
        case (size)
            SZ_BYTE: wd = {4{d[7:0]}};
            SZ_HALF: wd = {2{d[15:0]}};
            default: wd = d;
        endcase
        return wd;
    endfunction

    // Extract the addressed lane from the read word and extend it.
    function automatic logic [31:0] f_load_data(input logic [1:0]  size,
                                                input logic        sext,
                                                input logic [1:0]  a,
                                                input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (a)
            2'd0:    b = rdata[7:0];
            2'd1:    b = rdata[15:8];
            2'd2:    b = rdata[23:16];
            default: b = rdata[31:24];
        endcase
        h = a[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            SZ_BYTE: res = {{24{sext & b[7]}}, b};
            SZ_HALF: res = {{16{sext & h[15]}}, h};
            default: res = rdata;
        endcase
        return res;
    endfunction

    // ------------------------------------------------------------------
    // Stage register
    // ------------------------------------------------------------------
    logic [31:0] r_pc;
    logic [31:0] r_nextpc;
    logic [31:0] r_alu_res;
    logic [31:0] r_mem_data;
    logic [4:0]  r_rd;
    logic        r_w_rd;
    logic        r_link;
    logic        r_mem_rd;
    logic        r_mem_wr;
    logic [1:0]  r_mem_size;
    logic        r_mem_sext;
    logic        r_bubble;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        w_mem_op;
    logic        w_is_load;
    logic        w_req;
    logic        w_stall;
    logic        w_done;
    logic        w_wb_hold;

    // Capture the execute outputs unless stalled. Reset overrides the stall
    // and forces a bubble into the slot, so an abandoned access cannot
    // restart.
    always_ff @(posedge clk) begin
        if (rst || !w_stall) begin
            r_pc       <= ex_pc;
            r_nextpc   <= ex_nextpc;
            r_alu_res  <= ex_alu_res;
            r_mem_data <= ex_mem_data;
            r_rd       <= ex_rd;
            r_w_rd     <= ex_w_rd;
            r_link     <= ex_link;
            r_mem_rd   <= ex_mem_rd;
            r_mem_wr   <= ex_mem_wr;
            r_mem_size <= ex_mem_size;
            r_mem_sext <= ex_mem_sext;
            r_bubble   <= ex_bubble | rst;
        end
    end

    // A live slot that carries a load or a store needs the bus. When both
    // flags are set, the instruction is handled as a store.
    assign w_mem_op  = !r_bubble && (r_mem_rd || r_mem_wr);
    assign w_is_load = r_mem_rd && !r_mem_wr;

    // ------------------------------------------------------------------
    // Access FSM
    // ------------------------------------------------------------------

    // State register. Reset abandons any outstanding access.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and bus handshake. Stall drops in the acknowledge
    // cycle, so the next instruction enters on that same edge.
    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        w_stall     = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_mem_op) begin
                    w_req       = 1'b1;
                    w_stall     = 1'b1;
                    w_state_nxt = S_BUSY;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_BUSY: begin
                if (!w_mem_op) begin
                    w_state_nxt = S_IDLE;
                end else if (dbus.dbus_ack) begin
                    w_req       = 1'b1;
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_req       = 1'b1;
                    w_stall     = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Bus drive. The address, enables and data come straight from the stage
    // register, so they stay stable for the whole access.
    // ------------------------------------------------------------------
    assign dbus.dbus_req   = w_req;
    assign dbus.dbus_we    = r_mem_wr;
    assign dbus.dbus_addr  = {r_alu_res[31:2], 2'b00};
    assign dbus.dbus_be    = f_byte_en(r_mem_size, r_alu_res[1:0]);
    assign dbus.dbus_wdata = f_store_data(r_mem_size, r_mem_data);
    assign stall           = w_stall;

    // ------------------------------------------------------------------
    // Writeback. A memory op is hidden from writeback until it completes.
    // Writeback therefore sees exactly one non-bubble cycle per instruction.
    // ------------------------------------------------------------------
    assign w_wb_hold = w_mem_op && !w_done;
    assign wb_pc     = r_pc;
    assign wb_rd     = r_rd;
    assign wb_w_rd   = r_w_rd && !r_bubble && !w_wb_hold;
    assign wb_bubble = r_bubble || w_wb_hold;

    // Select the writeback value: load data, the link address or the ALU
    // result.
    always_comb begin
        wb_data = r_alu_res;
        if (w_mem_op && w_is_load) begin
            wb_data = f_load_data(r_mem_size, r_mem_sext, r_alu_res[1:0],
                                  dbus.dbus_rdata);
        end else if (r_link) begin
            wb_data = r_nextpc;
        end else begin
            wb_data = r_alu_res;
        end
    end

endmodule

// File: tb/tb_stage_mem.sv
// Directed testbench for stage_mem. Inputs are driven 1 time unit after the
// rising edge, and outputs are checked on the falling edge. Every expected
// value is hand-computed from the intended behaviour.
module tb_stage_mem;

    logic        clk;
    logic        rst;
    logic [31:0] ex_pc, ex_nextpc, ex_alu_res, ex_mem_data;
    logic [4:0]  ex_rd;
    logic        ex_w_rd, ex_link, ex_mem_rd, ex_mem_wr, ex_mem_sext, ex_bubble;
    logic [1:0]  ex_mem_size;
    logic        stall;
    logic [31:0] wb_pc, wb_data;
    logic [4:0]  wb_rd;
    logic        wb_w_rd, wb_bubble;

    int n_checks = 0;
    int n_errors = 0;

    stage_mem_if dbus_if ();

    stage_mem dut (
        .clk         (clk),
        .rst         (rst),
        .ex_pc       (ex_pc),
        .ex_nextpc   (ex_nextpc),
        .ex_alu_res  (ex_alu_res),
        .ex_mem_data (ex_mem_data),
        .ex_rd       (ex_rd),
        .ex_w_rd     (ex_w_rd),
        .ex_link     (ex_link),
        .ex_mem_rd   (ex_mem_rd),
        .ex_mem_wr   (ex_mem_wr),
        .ex_mem_size (ex_mem_size),
        .ex_mem_sext (ex_mem_sext),
        .ex_bubble   (ex_bubble),
        .dbus        (dbus_if),
        .stall       (stall),
        .wb_pc       (wb_pc),
        .wb_rd       (wb_rd),
        .wb_w_rd     (wb_w_rd),
        .wb_data     (wb_data),
        .wb_bubble   (wb_bubble)
    );

    // Free-running clock with a 10-unit period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drv_nop();
        ex_pc = 32'h0; ex_nextpc = 32'h0; ex_alu_res = 32'h0; ex_mem_data = 32'h0;
        ex_rd = 5'd0; ex_w_rd = 1'b0; ex_link = 1'b0; ex_mem_rd = 1'b0;
        ex_mem_wr = 1'b0; ex_mem_size = 2'd0; ex_mem_sext = 1'b0; ex_bubble = 1'b1;
    endtask

    task automatic drv_ex(input logic [31:0] pc, input logic [31:0] npc,
                          input logic [31:0] alu, input logic [31:0] mdata,
                          input logic [4:0] rd, input logic w_rd,
                          input logic link, input logic mrd, input logic mwr,
                          input logic [1:0] size, input logic sext);
        ex_pc = pc; ex_nextpc = npc; ex_alu_res = alu; ex_mem_data = mdata;
        ex_rd = rd; ex_w_rd = w_rd; ex_link = link; ex_mem_rd = mrd;
        ex_mem_wr = mwr; ex_mem_size = size; ex_mem_sext = sext; ex_bubble = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        drv_nop();
        dbus_if.dbus_ack   = 1'b0;
        dbus_if.dbus_rdata = 32'h0;
        repeat (2) cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_req",    {31'd0, dbus_if.dbus_req}, 32'd0);
        chk("rst_stall",  {31'd0, stall},            32'd0);
        chk("rst_bubble", {31'd0, wb_bubble},        32'd1);
        chk("rst_wrd",    {31'd0, wb_w_rd},          32'd0);

        // ALU op
        cyc(); drv_ex(32'h1000, 32'h1004, 32'h1234, 32'h0, 5'd5, 1'b1, 1'b0,
                      1'b0, 1'b0, 2'd2, 1'b0);
        cyc(); drv_nop();
        @(negedge clk);
        chk("alu_data",  wb_data,                   32'h1234);
        chk("alu_rd",    {27'd0, wb_rd},            32'd5);
        chk("alu_wrd",   {31'd0, wb_w_rd},          32'd1);
        chk("alu_pc",    wb_pc,                     32'h1000);
        chk("alu_stall", {31'd0, stall},            32'd0);
        chk("alu_req",   {31'd0, dbus_if.dbus_req}, 32'd0);
        chk("alu_bub",   {31'd0, wb_bubble},        32'd0);

        // Signed byte load at 0x103, acknowledged 3 cycles after the request
        cyc(); drv_ex(32'h2000, 32'h2004, 32'h103, 32'h0, 5'd7, 1'b1, 1'b0,
                      1'b1, 1'b0, 2'd0, 1'b1);
        cyc(); drv_nop();
        @(negedge clk);
        chk("lb_req",   {31'd0, dbus_if.dbus_req}, 32'd1);
        chk("lb_addr",  dbus_if.dbus_addr,         32'h100);
        chk("lb_be",    {28'd0, dbus_if.dbus_be},  32'h8);
        chk("lb_we",    {31'd0, dbus_if.dbus_we},  32'd0);
        chk("lb_stall", {31'd0, stall},            32'd1);
        chk("lb_bub0",  {31'd0, wb_bubble},        32'd1);
        chk("lb_wrd0",  {31'd0, wb_w_rd},          32'd0);
        for (int i = 0; i < 2; i++) begin
            cyc();
            @(negedge clk);
            chk("lb_wait_stall", {31'd0, stall},            32'd1);
            chk("lb_wait_req",   {31'd0, dbus_if.dbus_req}, 32'd1);
            chk("lb_wait_bub",   {31'd0, wb_bubble},        32'd1);
        end
        cyc(); dbus_if.dbus_ack = 1'b1; dbus_if.dbus_rdata = 32'h80FF_0011;
        @(negedge clk);
        chk("lb_ack_stall", {31'd0, stall},     32'd0);
        chk("lb_data",      wb_data,            32'hFFFF_FF80);
        chk("lb_wrd",       {31'd0, wb_w_rd},   32'd1);
        chk("lb_bub",       {31'd0, wb_bubble}, 32'd0);
        chk("lb_rd",        {27'd0, wb_rd},     32'd7);

        // Half store at 0x202
        cyc(); dbus_if.dbus_ack = 1'b0;
        drv_ex(32'h3000, 32'h3004, 32'h202, 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b0,
               1'b0, 1'b1, 2'd1, 1'b0);
        @(negedge clk);
        chk("lb_after_req", {31'd0, dbus_if.dbus_req}, 32'd0);
        chk("lb_after_bub", {31'd0, wb_bubble},        32'd1);
        cyc(); drv_nop();
        @(negedge clk);
        chk("sh_we",    {31'd0, dbus_if.dbus_we},  32'd1);
        chk("sh_be",    {28'd0, dbus_if.dbus_be},  32'hC);
        chk("sh_wdata", dbus_if.dbus_wdata,        32'hBEEF_BEEF);
        chk("sh_addr",  dbus_if.dbus_addr,         32'h200);
        chk("sh_stall", {31'd0, stall},            32'd1);
        cyc();
        @(negedge clk);
        chk("sh_hold_wdata", dbus_if.dbus_wdata,       32'hBEEF_BEEF);
        chk("sh_hold_be",    {28'd0, dbus_if.dbus_be}, 32'hC);
        chk("sh_hold_addr",  dbus_if.dbus_addr,        32'h200);
        cyc(); dbus_if.dbus_ack = 1'b1;
        @(negedge clk);
        chk("sh_ack_stall", {31'd0, stall},     32'd0);
        chk("sh_wrd",       {31'd0, wb_w_rd},   32'd0);
        chk("sh_bub",       {31'd0, wb_bubble}, 32'd0);

        // Back-to-back loads: a word at 0x10, then an unsigned half at 0x16
        cyc(); dbus_if.dbus_ack = 1'b0;
        drv_ex(32'h4000, 32'h4004, 32'h10, 32'h0, 5'd1, 1'b1, 1'b0,
               1'b1, 1'b0, 2'd2, 1'b0);
        cyc(); drv_ex(32'h4004, 32'h4008, 32'h16, 32'h0, 5'd2, 1'b1, 1'b0,
                      1'b1, 1'b0, 2'd1, 1'b0);
        @(negedge clk);
        chk("b2b_req0",  {31'd0, dbus_if.dbus_req}, 32'd1);
        chk("b2b_addr0", dbus_if.dbus_addr,         32'h10);
        chk("b2b_be0",   {28'd0, dbus_if.dbus_be},  32'hF);
        cyc(); dbus_if.dbus_ack = 1'b1; dbus_if.dbus_rdata = 32'h1234_5678;
        @(negedge clk);
        chk("b2b_req1",  {31'd0, dbus_if.dbus_req}, 32'd1);
        chk("b2b_data0", wb_data,                   32'h1234_5678);
        chk("b2b_rd0",   {27'd0, wb_rd},            32'd1);
        cyc(); dbus_if.dbus_ack = 1'b0; drv_nop();
        @(negedge clk);
        chk("b2b_req2",  {31'd0, dbus_if.dbus_req}, 32'd1);
        chk("b2b_addr1", dbus_if.dbus_addr,         32'h14);
        chk("b2b_be1",   {28'd0, dbus_if.dbus_be},  32'hC);
        chk("b2b_stall", {31'd0, stall},            32'd1);
        cyc(); dbus_if.dbus_ack = 1'b1; dbus_if.dbus_rdata = 32'hABCD_0000;
        @(negedge clk);
        chk("b2b_req3",  {31'd0, dbus_if.dbus_req}, 32'd1);
        chk("b2b_data1", wb_data,                   32'h0000_ABCD);
        chk("b2b_rd1",   {27'd0, wb_rd},            32'd2);

        // Link
        cyc(); dbus_if.dbus_ack = 1'b0;
        drv_ex(32'h40, 32'h44, 32'h999, 32'h0, 5'd31, 1'b1, 1'b1,
               1'b0, 1'b0, 2'd2, 1'b0);
        @(negedge clk);
        chk("b2b_end_req", {31'd0, dbus_if.dbus_req}, 32'd0);
        // The next instruction is a load that reset will interrupt
        cyc(); drv_ex(32'h50, 32'h54, 32'h300, 32'h0, 5'd9, 1'b1, 1'b0,
                      1'b1, 1'b0, 2'd2, 1'b0);
        @(negedge clk);
        chk("link_data", wb_data,          32'h44);
        chk("link_rd",   {27'd0, wb_rd},   32'd31);
        chk("link_wrd",  {31'd0, wb_w_rd}, 32'd1);

        // Reset mid-access, then a late ack
        cyc(); drv_nop();
        @(negedge clk);
        chk("rb_req_idle", {31'd0, dbus_if.dbus_req}, 32'd1);
        cyc(); rst = 1'b1;
        @(negedge clk);
        chk("rb_busy_stall", {31'd0, stall}, 32'd1);
        cyc(); rst = 1'b0;
        @(negedge clk);
        chk("rb_req",   {31'd0, dbus_if.dbus_req}, 32'd0);
        chk("rb_stall", {31'd0, stall},            32'd0);
        chk("rb_bub",   {31'd0, wb_bubble},        32'd1);
        cyc(); dbus_if.dbus_ack = 1'b1; dbus_if.dbus_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("rb_late_req",   {31'd0, dbus_if.dbus_req}, 32'd0);
        chk("rb_late_stall", {31'd0, stall},            32'd0);
        chk("rb_late_bub",   {31'd0, wb_bubble},        32'd1);
        chk("rb_late_wrd",   {31'd0, wb_w_rd},          32'd0);

        // A bubble that carries a load flag must not touch the bus
        cyc(); dbus_if.dbus_ack = 1'b0;
        drv_ex(32'h60, 32'h64, 32'h400, 32'h0, 5'd3, 1'b1, 1'b0,
               1'b1, 1'b0, 2'd2, 1'b0);
        ex_bubble = 1'b1;
        cyc(); drv_nop();
        @(negedge clk);
        chk("bub_req",   {31'd0, dbus_if.dbus_req}, 32'd0);
        chk("bub_stall", {31'd0, stall},            32'd0);
        chk("bub_wrd",   {31'd0, wb_w_rd},          32'd0);

        // Byte store at offset 1: lane 1 enabled, data replicated
        cyc(); drv_ex(32'h70, 32'h74, 32'h501, 32'h0000_00A5, 5'd0, 1'b0, 1'b0,
                      1'b0, 1'b1, 2'd0, 1'b0);
        cyc(); drv_nop();
        @(negedge clk);
        chk("sb_be",    {28'd0, dbus_if.dbus_be}, 32'h2);
        chk("sb_wdata", dbus_if.dbus_wdata,       32'hA5A5_A5A5);
        chk("sb_addr",  dbus_if.dbus_addr,        32'h500);
        cyc(); dbus_if.dbus_ack = 1'b1;
        cyc(); dbus_if.dbus_ack = 1'b0;
        @(negedge clk);
        chk("sb_done_req", {31'd0, dbus_if.dbus_req}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
